// File: rtl/input_port_bank_irq.sv
// Multi-port synchronised input bank with per-port maskable interrupts and a
// prioritised request/acknowledge handshake toward the control unit.
module input_port_bank_irq #(
    parameter int WIDTH       = 8,
    parameter int NUM_PORTS   = 4,
    parameter int SEL_W       = $clog2(NUM_PORTS),
    parameter int SYNC_STAGES = 2,
    parameter int IRQ_MODE    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS*WIDTH-1:0] in_ports,
    input  logic [SEL_W-1:0]           sel_port,
    output logic [WIDTH-1:0]           out,
    input  logic [NUM_PORTS-1:0]       irq_en,
    input  logic                       irq_ack,
    output logic                       interrupt,
    output logic [SEL_W-1:0]           irq_src,
    output logic [NUM_PORTS-1:0]       irq_pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [WIDTH-1:0]     sync_q [NUM_PORTS][SYNC_STAGES];
    logic [WIDTH-1:0]     sync_d [NUM_PORTS][SYNC_STAGES];
    logic [WIDTH-1:0]     prev_q [NUM_PORTS];
    logic [WIDTH-1:0]     prev_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] pending_q, pending_d;
    logic [NUM_PORTS-1:0] event_w, clr_w;
    logic [SEL_W-1:0]     irq_src_q, irq_src_d;
    logic [SEL_W-1:0]     lowest_idx;
    state_t               state_q, state_d;

    // Synchroniser chains and the one-cycle-delayed copy used for edge detection.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                if (j == 0) sync_d[i][j] = in_ports[i*WIDTH +: WIDTH];
                else        sync_d[i][j] = sync_q[i][j-1];
            end
            prev_d[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        out = '0;
        if (int'(sel_port) < NUM_PORTS) out = sync_q[sel_port][SYNC_STAGES-1];
    end

    // A set in the same cycle as the acknowledge clear wins, so no event is lost.
    always_comb begin
        event_w   = '0;
        pending_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            event_w[i] = irq_en[i] && (sync_q[i][SYNC_STAGES-1] != '0) &&
                         ((IRQ_MODE == 0) || (prev_q[i] == '0));
            if (IRQ_MODE != 0)
                pending_d[i] = irq_en[i] && (event_w[i] || (pending_q[i] && !clr_w[i]));
            else
                pending_d[i] = event_w[i];
        end
    end

    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (pending_q[i]) lowest_idx = SEL_W'(i);
        end
    end

    // Source is latched on entry to REQ and frozen until the acknowledge.
    always_comb begin
        state_d   = state_q;
        irq_src_d = irq_src_q;
        clr_w     = '0;
        interrupt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    irq_src_d = lowest_idx;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                interrupt = 1'b1;
                if (irq_ack) begin
                    clr_w[irq_src_q] = 1'b1;
                    state_d          = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int j = 0; j < SYNC_STAGES; j++) sync_q[i][j] <= '0;
                prev_q[i] <= '0;
            end
            pending_q <= '0;
            irq_src_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int j = 0; j < SYNC_STAGES; j++) sync_q[i][j] <= sync_d[i][j];
                prev_q[i] <= prev_d[i];
            end
            pending_q <= pending_d;
            irq_src_q <= irq_src_d;
            state_q   <= state_d;
        end
    end

    assign irq_src     = irq_src_q;
    assign irq_pending = pending_q;

endmodule

// File: tb/tb_input_port_bank_irq.sv
// Bench for input_port_bank_irq: default edge-mode instance plus a wide level-mode
// instance, both checked every cycle against a behavioural model.
module tb_input_port_bank_irq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  in_a;  logic [1:0] sel_a; logic [7:0]  out_a; logic [3:0] en_a;
  logic ack_a, int_a;  logic [1:0] src_a; logic [3:0]  pend_a;
  logic [127:0] in_b;  logic [2:0] sel_b; logic [15:0] out_b; logic [7:0] en_b;
  logic ack_b, int_b;  logic [2:0] src_b; logic [7:0]  pend_b;

  input_port_bank_irq dut_a (
    .clk(clk), .reset(rst), .in_ports(in_a), .sel_port(sel_a), .out(out_a),
    .irq_en(en_a), .irq_ack(ack_a), .interrupt(int_a), .irq_src(src_a), .irq_pending(pend_a)
  );

  input_port_bank_irq #(.WIDTH(16), .NUM_PORTS(8), .SYNC_STAGES(3), .IRQ_MODE(0)) dut_b (
    .clk(clk), .reset(rst), .in_ports(in_b), .sel_port(sel_b), .out(out_b),
    .irq_en(en_b), .irq_ack(ack_b), .interrupt(int_b), .irq_src(src_b), .irq_pending(pend_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int np_of(int k);   return (k == 0) ? 4 : 8; endfunction
  function automatic int st_of(int k);   return (k == 0) ? 2 : 3; endfunction
  function automatic bit edge_of(int k); return (k == 0);         endfunction

  logic [15:0] m_samp [2][8][4];
  logic [15:0] m_prev [2][8];
  logic        m_pend [2][8];
  bit          m_serv [2];
  bit          m_gap  [2];
  int          m_src  [2];

  function automatic logic [15:0] in_of(int k, int p);
    if (k == 0) return {8'h00, in_a[p*8 +: 8]};
    return in_b[p*16 +: 16];
  endfunction
  function automatic logic en_of(int k, int p);
    return (k == 0) ? en_a[p] : en_b[p];
  endfunction
  function automatic logic ack_of(int k);
    return (k == 0) ? ack_a : ack_b;
  endfunction
  function automatic int sel_of(int k);
    return (k == 0) ? int'(sel_a) : int'(sel_b);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 8; p++) begin
        for (int j = 0; j < 4; j++) m_samp[k][p][j] = '0;
        m_prev[k][p] = '0;
        m_pend[k][p] = 1'b0;
      end
      m_serv[k] = 0; m_gap[k] = 0; m_src[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    logic [15:0] sv [8];
    logic        nxt [8];
    bit          ev, clr;
    int          low;
    for (int p = 0; p < np_of(k); p++) begin
      sv[p]  = m_samp[k][p][st_of(k)-1];
      ev     = en_of(k, p) && (sv[p] != 0) && (!edge_of(k) || m_prev[k][p] == 0);
      clr    = m_serv[k] && ack_of(k) && (m_src[k] == p);
      nxt[p] = edge_of(k) ? (en_of(k, p) && (ev || (m_pend[k][p] && !clr))) : ev;
    end
    low = -1;
    for (int p = np_of(k) - 1; p >= 0; p--) if (m_pend[k][p]) low = p;
    if (m_serv[k]) begin
      if (ack_of(k)) begin m_serv[k] = 0; m_gap[k] = 1; end
    end else if (m_gap[k]) begin
      m_gap[k] = 0;
    end else if (low >= 0) begin
      m_serv[k] = 1; m_src[k] = low;
    end
    for (int p = 0; p < np_of(k); p++) begin
      m_prev[k][p] = sv[p];
      for (int j = 3; j > 0; j--) m_samp[k][p][j] = m_samp[k][p][j-1];
      m_samp[k][p][0] = in_of(k, p);
      m_pend[k][p]    = nxt[p];
    end
  endtask

  function automatic logic [15:0] exp_out(int k);
    int s = sel_of(k);
    if (s < np_of(k)) return m_samp[k][s][st_of(k)-1];
    return '0;
  endfunction
  function automatic logic [7:0] exp_pend(int k);
    logic [7:0] v = '0;
    for (int p = 0; p < np_of(k); p++) v[p] = m_pend[k][p];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("a_out",  out_a,  exp_out(0));
    chk("a_irq",  int_a,  m_serv[0]);
    chk("a_src",  src_a,  m_src[0]);
    chk("a_pend", pend_a, exp_pend(0));
    chk("b_out",  out_b,  exp_out(1));
    chk("b_irq",  int_b,  m_serv[1]);
    chk("b_src",  src_b,  m_src[1]);
    chk("b_pend", pend_b, exp_pend(1));
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_a = '0; sel_a = 2'd2; en_a = '0; ack_a = 1'b0;
    in_b = '0; sel_b = 3'd0; en_b = '0; ack_b = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_out", out_a, 32'h0);
    chk("rst_irq", int_a, 32'h0);
    chk("rst_pend", pend_a, 32'h0);

    // Edge mode latency: port1 = 0x5A before edge 1.
    in_a[15:8] = 8'h5A; sel_a = 2'd1; en_a = 4'b0010;
    step(1); chk("lat_out_e1", out_a, 32'h00);
    step(1); chk("lat_out_e2", out_a, 32'h5A);
    step(1); chk("lat_pend_e3", pend_a, 32'b0010); chk("lat_irq_e3", int_a, 32'h0);
    step(1); chk("lat_irq_e4", int_a, 32'h1);      chk("lat_src_e4", src_a, 32'h1);
    step(1); ack_a = 1'b1;
    step(1); ack_a = 1'b0;
    chk("ack_irq_e6", int_a, 32'h0); chk("ack_pend_e6", pend_a, 32'h0);
    step(4); chk("no_rereq", int_a, 32'h0);

    // Priority and freeze: port3 request, then port0 arrives during REQ.
    en_a = 4'b1001; in_a[31:24] = 8'h11;
    step(4); chk("pri_irq", int_a, 32'h1); chk("pri_src3", src_a, 32'h3);
    in_a[7:0] = 8'h22;
    step(4); chk("frz_src3", src_a, 32'h3); chk("frz_pend", pend_a, 32'b1001);
    ack_a = 1'b1; step(1); ack_a = 1'b0;
    chk("gap_irq", int_a, 32'h0); chk("gap_pend", pend_a, 32'b0001);
    step(1); chk("idle_irq", int_a, 32'h0);
    step(1); chk("next_irq", int_a, 32'h1); chk("next_src0", src_a, 32'h0);
    ack_a = 1'b1; step(1); ack_a = 1'b0;

    // Set/clear collision on port2.
    en_a = 4'b0100; in_a = {8'h00, 8'h33, 8'h00, 8'h00};
    step(4); chk("col_irq", int_a, 32'h1); chk("col_src2", src_a, 32'h2);
    in_a[23:16] = 8'h00; step(1);
    in_a[23:16] = 8'h44; step(2);
    ack_a = 1'b1; step(1); ack_a = 1'b0;
    chk("col_pend", pend_a, 32'b0100); chk("col_gap", int_a, 32'h0);
    step(1); chk("col_idle", int_a, 32'h0);
    step(1); chk("col_rereq", int_a, 32'h1); chk("col_src", src_a, 32'h2);

    // Asynchronous reset while in REQ.
    rst = 1'b1; #1;
    chk("arst_irq", int_a, 32'h0); chk("arst_pend", pend_a, 32'h0);
    step(1); en_a = '0; rst = 1'b0;
    chk("arst_after", int_a, 32'h0);

    // Masked event is discarded in edge mode.
    in_a = '0; step(4);
    in_a[7:0] = 8'h01; step(4);
    en_a = 4'b0001; step(3);
    chk("mask_pend", pend_a, 32'h0); chk("mask_irq", int_a, 32'h0);
    en_a = '0;

    // Wide level-mode instance: port7 = 0xBEEF.
    in_b[127:112] = 16'hBEEF; sel_b = 3'd7; en_b = 8'h80;
    step(2); chk("b_out_e2", out_b, 32'h0);
    step(1); chk("b_out_e3", out_b, 32'hBEEF);
    step(1); chk("b_pend_e4", pend_b, 32'h80); chk("b_irq_e4", int_b, 32'h0);
    step(1); chk("b_irq_e5", int_b, 32'h1); chk("b_src7", src_b, 32'h7);
    ack_b = 1'b1; step(1); ack_b = 1'b0;
    chk("b_ack_irq", int_b, 32'h0); chk("b_lvl_pend", pend_b, 32'h80);
    step(2); chk("b_rereq", int_b, 32'h1);
    en_b = 8'h00; step(2);
    chk("b_hold_req", int_b, 32'h1); chk("b_drop_pend", pend_b, 32'h0);
    ack_b = 1'b1; step(1); ack_b = 1'b0;
    chk("b_ack_nop", int_b, 32'h0);
    in_b = '0; step(5);

    // Level mode: masked value becomes pending one edge after enable.
    in_b[15:0] = 16'h0001; step(4);
    chk("b_mask_pre", pend_b, 32'h0);
    en_b = 8'h01; step(1);
    chk("b_mask_en", pend_b, 32'h01);
    en_b = '0; step(6);

    // Randomised traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 3) == 0)
          in_a[p*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int p = 0; p < 8; p++)
        if ($urandom_range(0, 3) == 0)
          in_b[p*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'h0000 : 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 15) == 0) en_a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) en_b = 8'($urandom_range(0, 255));
      sel_a = 2'($urandom_range(0, 3));
      sel_b = 3'($urandom_range(0, 7));
      ack_a = ($urandom_range(0, 3) == 0);
      ack_b = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_port_bank_irq.md
Name: input_port_bank_irq

Overview:
- Parametrised successor of the processor's fixed four-port, 8-bit input stage.
- Synchronises NUM_PORTS external input ports of WIDTH bits each, and presents the port chosen by sel_port on out to the datapath.
- Replaces the old single-port "any bit set" interrupt with per-port maskable interrupt sources and a prioritised request/acknowledge handshake toward the control unit.

Parameters:
- WIDTH, 8: bits per input port.
- NUM_PORTS, 4: number of input ports; minimum 2.
- SEL_W, $clog2(NUM_PORTS): width of sel_port and irq_src; derived, not overridden.
- SYNC_STAGES, 2: synchroniser flops per port; minimum 1.
- IRQ_MODE, 1: 0 = level mode (pending tracks live nonzero value); 1 = edge mode (latched on zero->nonzero transition).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_ports  input  NUM_PORTS*WIDTH  packed external ports; port i = bits [i*WIDTH +: WIDTH].
- sel_port  input  SEL_W  datapath read select.
- out  output  WIDTH  synchronised value of the selected port.
- irq_en  input  NUM_PORTS  per-port interrupt enable mask.
- irq_ack  input  1  interrupt acknowledge from the control unit.
- interrupt  output  1  interrupt request to the control unit.
- irq_src  output  SEL_W  index of the port being serviced; valid while interrupt=1.
- irq_pending  output  NUM_PORTS  raw pending bits, for status reads.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high, named reset; clock is named clk.
- Reset values: all synchroniser flops 0, pending 0, FSM in IDLE, interrupt 0, irq_src 0, out 0.
- Synchronisers: each port passes through a chain of SYNC_STAGES registers; sync_q[i] is the last stage.
- Read path:
  - out = sync_q[sel_port], combinational from the registers.
  - A new input value reaches out after SYNC_STAGES rising edges.
  - sel_port >= NUM_PORTS gives out = 0.
  - Reading a port never affects pending.
- Event detection:
  - prev[i] holds sync_q[i] delayed by one cycle.
  - Edge mode: event[i] = irq_en[i] & (sync_q[i] != 0) & (prev[i] == 0).
  - Level mode: event[i] = irq_en[i] & (sync_q[i] != 0).
- Pending register, updated every edge:
  - Edge mode: pending[i] <= irq_en[i] & (event[i] | (pending[i] & ~clr[i])).
  - Level mode: pending[i] <= event[i].
  - clr[i] = 1 only when the ack is accepted and irq_src == i.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Deasserting irq_en[i] drops pending[i] on the next edge.
  - Events on masked ports are discarded, not remembered.
- Handshake FSM, three states:
  - IDLE: interrupt=0. If any pending bit is set, latch irq_src = lowest pending index and go to REQ.
  - REQ: interrupt=1 and irq_src is frozen; higher-priority arrivals do not preempt it. irq_ack=1 clears pending[irq_src] and moves to GAP.
  - GAP: interrupt=0 for exactly one cycle, then IDLE.
  - irq_ack in IDLE or GAP is ignored.
  - If irq_src's pending bit is dropped by irq_en while in REQ, the FSM still waits for irq_ack; the ack then clears nothing.
- Latency in edge mode, input changes 0->nonzero before edge 1:
  - sync_q valid after edge SYNC_STAGES.
  - pending set after edge SYNC_STAGES+1.
  - interrupt=1 after edge SYNC_STAGES+2.
  - After an ack sampled at edge k: interrupt=0 after edge k. Any next request rises after edge k+2 at the earliest.
- Reset mid-handshake: immediate return to IDLE with all pending cleared; no ack is required afterwards.

Test Plan:
- Reset, then in_ports all 0x00 and sel_port=2 -> out=0x00, interrupt=0, irq_pending=0000. Assert reset mid-REQ -> interrupt falls asynchronously, no edge needed.
- Edge mode, irq_en=4'b0010, port1 set to 0x5A before edge 1 -> out=0x5A (sel=1) after edge 2, irq_pending=0010 after edge 3, interrupt=1 with irq_src=1 after edge 4. irq_ack at edge 6 -> interrupt=0 after edge 6; port held at 0x5A, so no re-request.
- Priority and freeze: port3 event, then port0 event while in REQ(src=3) -> irq_src stays 3 until ack. After the GAP cycle, the next request shows irq_src=0.
- Set/clear collision: in edge mode, port2 falls to 0 then returns to nonzero so a new event lands in the same cycle as the ack of src=2 -> pending[2] remains 1 and interrupt re-asserts two edges after the ack.
- Mask behaviour: irq_en=0 while port0 goes 0->0x01, then irq_en set to 1 with the value held -> no pending, interrupt stays 0. With IRQ_MODE=0, the same sequence -> pending[0]=1 one edge after enable.
- Parametrisation: WIDTH=16, NUM_PORTS=8, SYNC_STAGES=3, port7=0xBEEF, sel_port=7 -> out=0xBEEF after edge 3. irq_src=7 when it is the only enabled pending port.
